// File: rtl/exc_commit_if.sv
// exc_commit_if
//   Bundles the MEM-stage exception inputs, the forwarded CP0 state and the
//   WB CP0 write port, together with the commit outputs towards cp0_reg and
//   the ctrl/pc_reg flush path.
//   Signal names carry the _i/_o suffix as seen from exc_commit.
//   modport slave  : used by exc_commit (consumes *_i, drives *_o)
//   modport master : used by the pipeline / testbench side
interface exc_commit_if;
  // MEM-stage instruction
  logic        inst_valid_i;
  logic        stall_i;
  logic [31:0] excflags_i;
  logic [31:0] inst_addr_i;
  logic        in_delayslot_i;
  // CP0 state as currently held in cp0_reg
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  // WB-stage CP0 write, forwarded over the cp0_reg values
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  // Commit outputs
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;

  modport slave (
    input  inst_valid_i, stall_i, excflags_i, inst_addr_i, in_delayslot_i,
    input  cp0_status_i, cp0_cause_i, cp0_epc_i,
    input  wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    output excepttype_o, current_inst_addr_o, is_in_delayslot_o,
    output flush_o, new_pc_o, busy_o
  );

  modport master (
    output inst_valid_i, stall_i, excflags_i, inst_addr_i, in_delayslot_i,
    output cp0_status_i, cp0_cause_i, cp0_epc_i,
    output wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    input  excepttype_o, current_inst_addr_o, is_in_delayslot_o,
    input  flush_o, new_pc_o, busy_o
  );
endinterface

// File: rtl/exc_commit.sv
// exc_commit
//   MEM-stage exception resolver and commit sequencer.
//   Resolves the highest-priority exception of the MEM instruction (with the
//   WB CP0 write forwarded over Status/Cause/EPC), registers the code,
//   instruction address and delay-slot flag for cp0_reg, and drives the
//   pipeline flush and redirect PC for one COMMIT cycle plus DRAIN_CYCLES
//   extra flush cycles.
//
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous reset, active low
//     bus  - exc_commit_if.slave (MEM inputs, CP0 values, WB write, outputs)
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | watching MEM; outputs 0
//   COMMIT | one cycle: exception code/addr/delay-slot valid, flush high
//   DRAIN  | extra flush cycles, new_pc held, code already cleared
module exc_commit #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0040,
  parameter int unsigned DRAIN_CYCLES = 1
) (
  input logic          clk,
  input logic          rst,
  exc_commit_if.slave  bus
);

  localparam logic [4:0]  ADDR_STATUS = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE  = 5'd13;
  localparam logic [4:0]  ADDR_EPC    = 5'd14;
  // Cause bits writable by software: IP1:IP0, IV, WP
  localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;
  localparam logic [1:0]  DRAIN_INIT  = 2'(DRAIN_CYCLES);

  localparam logic [31:0] EXC_NONE    = 32'h0;
  localparam logic [31:0] EXC_INT     = 32'h1;
  localparam logic [31:0] EXC_SYSCALL = 32'h8;
  localparam logic [31:0] EXC_INVALID = 32'ha;
  localparam logic [31:0] EXC_TRAP    = 32'hd;
  localparam logic [31:0] EXC_OV      = 32'hc;
  localparam logic [31:0] EXC_ERET    = 32'he;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_DRAIN  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] exc_q, exc_d;
  logic [31:0] addr_q, addr_d;
  logic        ds_q, ds_d;
  logic        flush_q, flush_d;
  logic [31:0] pc_q, pc_d;

  logic [31:0] status_eff;
  logic [31:0] cause_eff;
  logic [31:0] epc_eff;
  logic        int_pend;
  logic        detect;
  logic [31:0] win_code;

  // WB-stage CP0 write forwarding
  always_comb begin
    status_eff = bus.cp0_status_i;
    cause_eff  = bus.cp0_cause_i;
    epc_eff    = bus.cp0_epc_i;
    if (bus.wb_cp0_we_i) begin
      unique case (bus.wb_cp0_waddr_i)
        ADDR_STATUS: status_eff = bus.wb_cp0_data_i;
        ADDR_CAUSE:  cause_eff  = (bus.cp0_cause_i & ~CAUSE_WMASK) |
                                  (bus.wb_cp0_data_i & CAUSE_WMASK);
        ADDR_EPC:    epc_eff    = bus.wb_cp0_data_i;
        default:     ;
      endcase
    end
  end

  // Interrupt needs IE set and EXL clear on the forwarded Status
  assign int_pend = (|(cause_eff[15:8] & status_eff[15:8])) &&
                    status_eff[0] && !status_eff[1];

  assign detect = (state_q == S_IDLE) && bus.inst_valid_i && !bus.stall_i;

  always_comb begin
    win_code = EXC_NONE;
    if (int_pend)                win_code = EXC_INT;
    else if (bus.excflags_i[8])  win_code = EXC_SYSCALL;
    else if (bus.excflags_i[9])  win_code = EXC_INVALID;
    else if (bus.excflags_i[10]) win_code = EXC_TRAP;
    else if (bus.excflags_i[11]) win_code = EXC_OV;
    else if (bus.excflags_i[12]) win_code = EXC_ERET;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exc_d   = exc_q;
    addr_d  = addr_q;
    ds_d    = ds_q;
    flush_d = flush_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (detect && (win_code != EXC_NONE)) begin
          state_d = S_COMMIT;
          exc_d   = win_code;
          addr_d  = bus.inst_addr_i;
          ds_d    = bus.in_delayslot_i;
          flush_d = 1'b1;
          pc_d    = (win_code == EXC_ERET) ? epc_eff : EXC_VECTOR;
        end
      end
      S_COMMIT: begin
        // code/addr/delay-slot are a single-cycle pulse for cp0_reg
        exc_d  = EXC_NONE;
        addr_d = 32'h0;
        ds_d   = 1'b0;
        if (DRAIN_CYCLES > 0) begin
          state_d = S_DRAIN;
          cnt_d   = DRAIN_INIT;
        end else begin
          state_d = S_IDLE;
          flush_d = 1'b0;
          pc_d    = 32'h0;
        end
      end
      S_DRAIN: begin
        if (cnt_q <= 2'd1) begin
          state_d = S_IDLE;
          cnt_d   = 2'd0;
          flush_d = 1'b0;
          pc_d    = 32'h0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 2'd0;
        exc_d   = EXC_NONE;
        addr_d  = 32'h0;
        ds_d    = 1'b0;
        flush_d = 1'b0;
        pc_d    = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      exc_q   <= EXC_NONE;
      addr_q  <= 32'h0;
      ds_q    <= 1'b0;
      flush_q <= 1'b0;
      pc_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
      addr_q  <= addr_d;
      ds_q    <= ds_d;
      flush_q <= flush_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.excepttype_o        = exc_q;
  assign bus.current_inst_addr_o = addr_q;
  assign bus.is_in_delayslot_o   = ds_q;
  assign bus.flush_o             = flush_q;
  assign bus.new_pc_o            = pc_q;
  assign bus.busy_o              = (state_q != S_IDLE);

  // Flag and CP0 bits that play no part in exception resolution
  logic unused_ok;
  assign unused_ok = ^{bus.excflags_i[31:13], bus.excflags_i[7:0],
                       status_eff[31:16], status_eff[7:2],
                       cause_eff[31:16], cause_eff[7:0]};

endmodule

// File: tb/tb_exc_commit.sv
module tb_exc_commit;
  localparam int          D   = 1;
  localparam logic [31:0] VEC = 32'h0000_0040;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  exc_commit_if bus();

  exc_commit #(.EXC_VECTOR(VEC), .DRAIN_CYCLES(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] code;
    logic [31:0] addr;
    logic        ds;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   blocked = 0;   // cycles the DUT is still busy with a prior exception

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exception code from the architectural rules
  function automatic exp_t ref_model(input logic v, input logic [31:0] fl,
                                     input logic [31:0] addr, input logic ds,
                                     input logic [31:0] st, input logic [31:0] ca,
                                     input logic [31:0] epc, input logic we,
                                     input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    logic [31:0] s, c, p;
    logic ip;
    s = st; c = ca; p = epc;
    if (we && wa == 5'd12) s = wd;
    if (we && wa == 5'd14) p = wd;
    if (we && wa == 5'd13) c = (ca & ~32'h00C0_0300) | (wd & 32'h00C0_0300);
    ip = ((((c >> 8) & (s >> 8)) & 32'hFF) != 0) && s[0] && !s[1];
    e.code = 0;
    if (v) begin
      if (ip)         e.code = 32'h1;
      else if (fl[8]) e.code = 32'h8;
      else if (fl[9]) e.code = 32'ha;
      else if (fl[10]) e.code = 32'hd;
      else if (fl[11]) e.code = 32'hc;
      else if (fl[12]) e.code = 32'he;
    end
    e.addr = addr;
    e.ds   = ds;
    e.pc   = (e.code == 32'he) ? p : VEC;
    return e;
  endfunction

  // Apply one cycle of inputs, predict, then advance past the edge
  task automatic drive(input logic v, input logic st, input logic [31:0] fl,
                       input logic [31:0] addr, input logic ds,
                       input logic [31:0] status, input logic [31:0] cause,
                       input logic [31:0] epc, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    bus.inst_valid_i   = v;
    bus.stall_i        = st;
    bus.excflags_i     = fl;
    bus.inst_addr_i    = addr;
    bus.in_delayslot_i = ds;
    bus.cp0_status_i   = status;
    bus.cp0_cause_i    = cause;
    bus.cp0_epc_i      = epc;
    bus.wb_cp0_we_i    = we;
    bus.wb_cp0_waddr_i = wa;
    bus.wb_cp0_data_i  = wd;
    if (blocked > 0) begin
      blocked--;
    end else if (v && !st) begin
      e = ref_model(v, fl, addr, ds, status, cause, epc, we, wa, wd);
      if (e.code != 0) begin
        sb.push_back(e);
        blocked = 1 + D;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h1000_0001, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // Monitor: pops the scoreboard on each flush rising edge
  int          run = 0;
  logic        prev_flush = 1'b0;
  logic [31:0] held_pc = 32'h0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      run = 0;
      prev_flush = 1'b0;
    end else begin
      if (bus.flush_o && !prev_flush) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_flush: got excepttype %h with empty queue at %0t",
                   bus.excepttype_o, $time);
        end else begin
          e = sb.pop_front();
          chk("excepttype", bus.excepttype_o, e.code);
          chk("inst_addr", bus.current_inst_addr_o, e.addr);
          chk("delayslot", {31'h0, bus.is_in_delayslot_o}, {31'h0, e.ds});
          chk("new_pc", bus.new_pc_o, e.pc);
        end
        held_pc = bus.new_pc_o;
        run = 1;
      end else if (bus.flush_o) begin
        run++;
        chk("drain_code_clear",
            bus.excepttype_o | bus.current_inst_addr_o | {31'h0, bus.is_in_delayslot_o}, 32'h0);
        chk("drain_pc_held", bus.new_pc_o, held_pc);
      end else begin
        if (prev_flush) chk("flush_len", run, 1 + D);
        chk("idle_outputs_zero",
            bus.excepttype_o | bus.current_inst_addr_o | bus.new_pc_o |
            {31'h0, bus.is_in_delayslot_o}, 32'h0);
      end
      chk("busy_vs_flush", {31'h0, bus.busy_o}, {31'h0, bus.flush_o});
      prev_flush = bus.flush_o;
    end
  end

  initial begin
    logic [31:0] fl, st, ca;
    logic [4:0]  wa;
    bus.inst_valid_i = 0; bus.stall_i = 0; bus.excflags_i = 0; bus.inst_addr_i = 0;
    bus.in_delayslot_i = 0; bus.cp0_status_i = 0; bus.cp0_cause_i = 0; bus.cp0_epc_i = 0;
    bus.wb_cp0_we_i = 0; bus.wb_cp0_waddr_i = 0; bus.wb_cp0_data_i = 0;
    #1;
    chk("reset_flush", {31'h0, bus.flush_o}, 32'h0);
    chk("reset_busy", {31'h0, bus.busy_o}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Quiet after reset
    repeat (20) idle_cycle();
    chk("quiet_busy", {31'h0, bus.busy_o}, 32'h0);

    // Syscall at 0x100
    drive(1, 0, 32'h100, 32'h100, 0, 32'h1000_0001, 0, 0, 0, 0, 0);
    chk("sys_flush_latency", {31'h0, bus.flush_o}, 32'h1);
    chk("sys_code", bus.excepttype_o, 32'h8);
    repeat (4) idle_cycle();

    // Interrupt beats trap and overflow
    drive(1, 0, 32'hC00, 32'h204, 1, 32'h1000_0401, 32'h400, 0, 0, 0, 0);
    chk("int_code", bus.excepttype_o, 32'h1);
    repeat (4) idle_cycle();

    // eret with forwarded EPC
    drive(1, 0, 32'h1000, 32'h208, 0, 32'h1000_0001, 0, 32'h80, 1, 5'd14, 32'h300);
    chk("eret_pc", bus.new_pc_o, 32'h300);
    repeat (4) idle_cycle();

    // WB clears IE in the same cycle as a pending interrupt
    drive(1, 0, 0, 32'h20c, 0, 32'h1000_0401, 32'h400, 0, 1, 5'd12, 32'h1000_0000);
    chk("ie_fwd_no_flush", {31'h0, bus.flush_o}, 32'h0);
    repeat (2) idle_cycle();

    // Stall suppresses detection; flag taken once stall releases
    drive(1, 1, 32'h800, 32'h210, 0, 32'h1000_0001, 0, 0, 0, 0, 0);
    chk("stall_no_flush", {31'h0, bus.flush_o}, 32'h0);
    drive(1, 0, 32'h800, 32'h210, 0, 32'h1000_0001, 0, 0, 0, 0, 0);
    chk("stall_release_code", bus.excepttype_o, 32'hc);
    repeat (4) idle_cycle();

    // Second exception during COMMIT ignored, then reset during DRAIN
    drive(1, 0, 32'h100, 32'h300, 0, 32'h1000_0001, 0, 0, 0, 0, 0);
    drive(1, 0, 32'h200, 32'h304, 1, 32'h1000_0001, 0, 0, 0, 0, 0);
    chk("drain_active", {31'h0, bus.flush_o}, 32'h1);
    #1 rst = 1'b0;
    blocked = 0;
    #1;
    chk("rst_async_outputs",
        bus.excepttype_o | bus.current_inst_addr_o | bus.new_pc_o |
        {31'h0, bus.is_in_delayslot_o} | {31'h0, bus.flush_o}, 32'h0);
    chk("rst_async_busy", {31'h0, bus.busy_o}, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    idle_cycle();
    chk("post_rst_busy", {31'h0, bus.busy_o}, 32'h0);
    repeat (2) idle_cycle();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      fl = $urandom & 32'hFFFF_E0FF;
      for (int b = 8; b <= 12; b++)
        if ($urandom_range(0, 7) == 0) fl[b] = 1'b1;
      st = $urandom;
      ca = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_00FF) : $urandom;
      case ($urandom_range(0, 3))
        0: wa = 5'd12;
        1: wa = 5'd13;
        2: wa = 5'd14;
        default: wa = 5'($urandom_range(0, 31));
      endcase
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, fl, $urandom,
            1'($urandom_range(0, 1)), st, ca, $urandom,
            $urandom_range(0, 2) == 0, wa, $urandom);
    end

    repeat (8) idle_cycle();
    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end
endmodule
